// File: rtl/tmr_ctrl_pkg.sv
// Shared types and constants for the TMR recovery controller: FSM states,
// voter disagreement encodings, core indices and small decode helpers.
package tmr_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_NORMAL  = 3'd0,
    ST_CONFIRM = 3'd1,
    ST_HOLD    = 3'd2,
    ST_RESYNC  = 3'd3,
    ST_RELEASE = 3'd4,
    ST_FATAL   = 3'd5
  } tmr_state_e;

  localparam logic [1:0] VS_AGREE = 2'b00;
  localparam logic [1:0] VS_A     = 2'b01;
  localparam logic [1:0] VS_B     = 2'b10;
  localparam logic [1:0] VS_C     = 2'b11;

  localparam logic [1:0] CORE_A = 2'd0;
  localparam logic [1:0] CORE_B = 2'd1;
  localparam logic [1:0] CORE_C = 2'd2;

  function automatic logic [1:0] vs_to_core(input logic [1:0] vs);
    case (vs)
      VS_A:    return CORE_A;
      VS_B:    return CORE_B;
      VS_C:    return CORE_C;
      default: return CORE_A;
    endcase
  endfunction

  function automatic logic [2:0] core_onehot(input logic [1:0] idx);
    case (idx)
      CORE_A:  return 3'b001;
      CORE_B:  return 3'b010;
      CORE_C:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // True once a majority can no longer be formed from the remaining cores.
  function automatic logic multi_disabled(input logic [2:0] mask);
    return (mask[0] & mask[1]) | (mask[0] & mask[2]) | (mask[1] & mask[2]);
  endfunction

endpackage

// File: rtl/tmr_recovery_ctrl_fault_counter.sv
// Per-core saturating recovery counter; limit_hit flags an increment that
// lands exactly on LIMIT so the controller can retire the core in the same cycle.
module tmr_fault_counter #(
  parameter int CNT_W = 4,
  parameter int LIMIT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             limit_hit
);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_inc_s;

  // Saturating increment value.
  always_comb begin
    if (cnt_r == {CNT_W{1'b1}}) begin
      cnt_inc_s = cnt_r;
    end else begin
      cnt_inc_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign limit_hit = inc && (cnt_inc_s == CNT_W'(LIMIT));
  assign cnt       = cnt_r;

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (inc) begin
      cnt_r <= cnt_inc_s;
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/tmr_recovery_ctrl.sv
// Fault confirmation / freeze / resync / release sequencer for the TMR core array.
// Optional build macro TMR_FAULT_LOG_EN adds fault counters and core retirement.
module tmr_recovery_ctrl
  import tmr_ctrl_pkg::*;
#(
  parameter int CONFIRM_CYCLES = 2,
  parameter int RESYNC_CYCLES  = 8,
  parameter int FAULT_LIMIT    = 3,
  parameter int CNT_W          = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       voter_state,
  input  logic             vote_fail,
  output logic             core_hold,
  output logic             mem_we_block,
  output logic [2:0]       core_rst_n,
  output logic [2:0]       core_load,
  output logic [2:0]       core_disabled,
  output logic [3*CNT_W-1:0] fault_cnt,
  output logic             fatal
);

  localparam int CONF_W = $clog2(CONFIRM_CYCLES + 1);
  localparam int RS_W   = $clog2(RESYNC_CYCLES + 1);

  tmr_state_e        state_r, state_nxt_s;
  logic [1:0]        suspect_r, suspect_nxt_s;
  logic [CONF_W-1:0] conf_cnt_r, conf_cnt_nxt_s;
  logic [RS_W-1:0]   rs_cnt_r, rs_cnt_nxt_s;
  logic [2:0]        hit_s, disabled_r, disabled_nxt_s;
  logic [1:0]        vs_core_s;
  logic              vs_valid_s;
  logic              freeze_s;
  logic [2:0]        load_s, rst_mask_s;

  assign vs_core_s  = vs_to_core(voter_state);
  assign vs_valid_s = (voter_state != VS_AGREE) && !disabled_r[vs_core_s];

`ifdef TMR_FAULT_LOG_EN
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cnt
      tmr_fault_counter #(.CNT_W(CNT_W), .LIMIT(FAULT_LIMIT)) u_cnt (
        .clk       (clk),
        .rst_n     (rst),
        .inc       ((state_r == ST_HOLD) && (suspect_r == 2'(gi))),
        .cnt       (fault_cnt[gi*CNT_W +: CNT_W]),
        .limit_hit (hit_s[gi])
      );
    end
  endgenerate

  assign disabled_nxt_s = disabled_r | hit_s;
  assign core_disabled  = disabled_r;

  // Sticky retired-core mask.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disabled_r <= 3'b000;
    end else begin
      disabled_r <= disabled_nxt_s;
    end
  end
`else
  assign hit_s          = 3'b000;
  assign disabled_r     = 3'b000;
  assign disabled_nxt_s = 3'b000;
  assign core_disabled  = 3'b000;
  assign fault_cnt      = {(3*CNT_W){1'b0}};
`endif

  // State, suspect and cycle counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_NORMAL;
      suspect_r  <= 2'd0;
      conf_cnt_r <= {CONF_W{1'b0}};
      rs_cnt_r   <= {RS_W{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      suspect_r  <= suspect_nxt_s;
      conf_cnt_r <= conf_cnt_nxt_s;
      rs_cnt_r   <= rs_cnt_nxt_s;
    end
  end

  // Next-state logic; vote_fail overrides every other condition.
  always_comb begin
    state_nxt_s    = state_r;
    suspect_nxt_s  = suspect_r;
    conf_cnt_nxt_s = conf_cnt_r;
    rs_cnt_nxt_s   = rs_cnt_r;
    if (vote_fail) begin
      state_nxt_s = ST_FATAL;
    end else begin
      case (state_r)
        ST_NORMAL: begin
          if (vs_valid_s) begin
            suspect_nxt_s  = vs_core_s;
            conf_cnt_nxt_s = CONF_W'(1);
            state_nxt_s    = (CONFIRM_CYCLES == 1) ? ST_HOLD : ST_CONFIRM;
          end else begin
            conf_cnt_nxt_s = {CONF_W{1'b0}};
          end
        end
        ST_CONFIRM: begin
          if (voter_state == VS_AGREE) begin
            state_nxt_s    = ST_NORMAL;
            conf_cnt_nxt_s = {CONF_W{1'b0}};
          end else if (!vs_valid_s) begin
            conf_cnt_nxt_s = conf_cnt_r;
          end else if (vs_core_s != suspect_r) begin
            suspect_nxt_s  = vs_core_s;
            conf_cnt_nxt_s = CONF_W'(1);
          end else if (conf_cnt_r == CONF_W'(CONFIRM_CYCLES - 1)) begin
            state_nxt_s    = ST_HOLD;
            conf_cnt_nxt_s = {CONF_W{1'b0}};
          end else begin
            conf_cnt_nxt_s = conf_cnt_r + CONF_W'(1);
          end
        end
        ST_HOLD: begin
          rs_cnt_nxt_s = {RS_W{1'b0}};
          if (hit_s[suspect_r]) begin
            state_nxt_s = multi_disabled(disabled_nxt_s) ? ST_FATAL : ST_NORMAL;
          end else begin
            state_nxt_s = ST_RESYNC;
          end
        end
        ST_RESYNC: begin
          if (rs_cnt_r == RS_W'(RESYNC_CYCLES - 1)) begin
            state_nxt_s  = ST_RELEASE;
            rs_cnt_nxt_s = {RS_W{1'b0}};
          end else begin
            rs_cnt_nxt_s = rs_cnt_r + RS_W'(1);
          end
        end
        ST_RELEASE: state_nxt_s = ST_NORMAL;
        ST_FATAL:   state_nxt_s = ST_FATAL;
        default:    state_nxt_s = ST_NORMAL;
      endcase
    end
  end

  // Output decode from the next state so registered outputs track the state register.
  always_comb begin
    freeze_s   = 1'b0;
    load_s     = 3'b000;
    rst_mask_s = disabled_nxt_s;
    case (state_nxt_s)
      ST_HOLD, ST_FATAL: freeze_s = 1'b1;
      ST_RESYNC: begin
        freeze_s   = 1'b1;
        rst_mask_s = disabled_nxt_s | core_onehot(suspect_nxt_s);
      end
      ST_RELEASE: begin
        freeze_s = 1'b1;
        load_s   = core_onehot(suspect_nxt_s);
      end
      default: freeze_s = 1'b0;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_hold    <= 1'b0;
      mem_we_block <= 1'b0;
      core_rst_n   <= 3'b111;
      core_load    <= 3'b000;
      fatal        <= 1'b0;
    end else begin
      core_hold    <= freeze_s;
      mem_we_block <= freeze_s;
      core_rst_n   <= ~rst_mask_s;
      core_load    <= load_s;
      fatal        <= (state_nxt_s == ST_FATAL);
    end
  end

endmodule

// File: tb/tb_tmr_recovery_ctrl.sv
// Scoreboard bench for tmr_recovery_ctrl: expected output vectors are queued as
// stimulus is driven and compared one cycle later against the DUT.
module tb_tmr_recovery_ctrl;

  typedef struct packed {
    logic       hold;
    logic       memblk;
    logic [2:0] rstn;
    logic [2:0] load;
    logic       fatal;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [1:0]  voter_state;
  logic        vote_fail;
  logic        core_hold;
  logic        mem_we_block;
  logic [2:0]  core_rst_n;
  logic [2:0]  core_load;
  logic [2:0]  core_disabled;
  logic [11:0] fault_cnt;
  logic        fatal;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  tmr_recovery_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .voter_state   (voter_state),
    .vote_fail     (vote_fail),
    .core_hold     (core_hold),
    .mem_we_block  (mem_we_block),
    .core_rst_n    (core_rst_n),
    .core_load     (core_load),
    .core_disabled (core_disabled),
    .fault_cnt     (fault_cnt),
    .fatal         (fatal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t got_vec();
    return {core_hold, mem_we_block, core_rst_n, core_load, fatal};
  endfunction

  // Spec timeline relative to the first suspect sample (cycle i = outputs after edge i).
  // kind 0 full recovery, 1 retire, 2 retire into fatal, 3 idle, 4 fatal.
  function automatic exp_t exp_fault(int i, logic [2:0] oh, logic [2:0] dm, int kind);
    exp_t e;
    e.hold = 1'b0; e.memblk = 1'b0; e.rstn = ~dm; e.load = 3'b000; e.fatal = 1'b0;
    if (kind == 3) return e;
    if (kind == 4 || (kind == 2 && i >= 2)) begin
      e.hold = 1'b1; e.memblk = 1'b1; e.fatal = 1'b1;
      if (kind == 2) e.rstn = ~(dm | oh);
      return e;
    end
    if (i == 0) return e;
    if (i == 1) begin e.hold = 1'b1; e.memblk = 1'b1; return e; end
    if (kind == 1) begin e.rstn = ~(dm | oh); return e; end
    if (i <= 9) begin
      e.hold = 1'b1; e.memblk = 1'b1; e.rstn = ~(dm | oh);
    end else if (i == 10) begin
      e.hold = 1'b1; e.memblk = 1'b1; e.load = oh;
    end
    return e;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; voter_state = 2'b00; vote_fail = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    exp_t e, got;
    rst = 1'b0; voter_state = 2'b00; vote_fail = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (got_vec() !== exp_fault(0, 3'b000, 3'b000, 3)) begin
      n_fail++;
      $display("FAIL reset_hold: got %b expected %b", got_vec(), exp_fault(0, 3'b000, 3'b000, 3));
    end
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(exp_fault(0, 3'b000, 3'b000, 3));
      @(negedge clk);
      got = got_vec(); e = exp_q.pop_front(); n_checks++;
      if (got !== e) begin n_fail++; $display("FAIL reset_idle cycle %0d: got %b expected %b", i, got, e); end
    end
    n_checks++;
    if ({core_disabled, fault_cnt} !== 15'd0) begin
      n_fail++; $display("FAIL reset_cnt: got %h/%h expected 0/0", core_disabled, fault_cnt);
    end
  endtask

  task automatic test_recovery_b();
    exp_t e, got;
    int   frz = 0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      voter_state = (i < 2) ? 2'b10 : 2'b00;
      exp_q.push_back(exp_fault(i, 3'b010, 3'b000, 0));
      @(negedge clk);
      got = got_vec(); e = exp_q.pop_front(); n_checks++;
      if (got[8]) frz++;
      if (got !== e) begin n_fail++; $display("FAIL recov_b cycle %0d: got %b expected %b", i, got, e); end
    end
    n_checks++;
    if (frz != 10) begin n_fail++; $display("FAIL recov_b_freeze: got %0d expected 10", frz); end
    n_checks++;
`ifdef TMR_FAULT_LOG_EN
    if (fault_cnt !== 12'h010) begin n_fail++; $display("FAIL recov_b_cnt: got %h expected 010", fault_cnt); end
`else
    if (fault_cnt !== 12'h000) begin n_fail++; $display("FAIL recov_b_cnt: got %h expected 000", fault_cnt); end
`endif
  endtask

  task automatic test_transient_a();
    exp_t e, got;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      voter_state = (i == 0) ? 2'b01 : 2'b00;
      exp_q.push_back(exp_fault(0, 3'b000, 3'b000, 3));
      @(negedge clk);
      got = got_vec(); e = exp_q.pop_front(); n_checks++;
      if (got !== e) begin n_fail++; $display("FAIL transient cycle %0d: got %b expected %b", i, got, e); end
    end
    n_checks++;
    if (fault_cnt[3:0] !== 4'd0) begin n_fail++; $display("FAIL transient_cnt: got %h expected 0", fault_cnt[3:0]); end
  endtask

  task automatic test_retire();
    exp_t       e, got;
    int         n;
`ifdef TMR_FAULT_LOG_EN
    int         nf = 8;
    logic [1:0] code[8] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b01, 2'b01, 2'b00};
    logic [2:0] oh[8]   = '{3'b100, 3'b100, 3'b100, 3'b000, 3'b001, 3'b001, 3'b001, 3'b000};
    logic [2:0] dm[8]   = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b100, 3'b100, 3'b100, 3'b101};
    int         kind[8] = '{0, 0, 1, 3, 0, 0, 2, 4};
`else
    int         nf = 4;
    logic [1:0] code[8] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
    logic [2:0] oh[8]   = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000};
    logic [2:0] dm[8]   = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    int         kind[8] = '{0, 0, 0, 0, 3, 3, 3, 3};
`endif
    do_reset();
    for (int f = 0; f < nf; f++) begin
      n = (kind[f] == 0) ? 12 : ((kind[f] >= 3) ? 4 : 3);
      for (int i = 0; i < n; i++) begin
        voter_state = (kind[f] == 3 || i < 2) ? code[f] : 2'b00;
        exp_q.push_back(exp_fault(i, oh[f], dm[f], kind[f]));
        @(negedge clk);
        got = got_vec(); e = exp_q.pop_front(); n_checks++;
        if (got !== e) begin
          n_fail++; $display("FAIL retire step %0d cycle %0d: got %b expected %b", f, i, got, e);
        end
      end
    end
    n_checks++;
`ifdef TMR_FAULT_LOG_EN
    if ({core_disabled, fault_cnt} !== {3'b101, 12'h303}) begin
      n_fail++; $display("FAIL retire_mask: got %b/%h expected 101/303", core_disabled, fault_cnt);
    end
`else
    if ({core_disabled, fault_cnt} !== 15'd0) begin
      n_fail++; $display("FAIL retire_mask: got %b/%h expected 000/000", core_disabled, fault_cnt);
    end
`endif
  endtask

  task automatic test_vote_fail();
    exp_t e, got;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      voter_state = (i < 2) ? 2'b01 : 2'b00;
      vote_fail   = (i == 1);
      exp_q.push_back(exp_fault(i, 3'b000, 3'b000, (i == 0) ? 3 : 4));
      @(negedge clk);
      got = got_vec(); e = exp_q.pop_front(); n_checks++;
      if (got !== e) begin n_fail++; $display("FAIL vote_fail cycle %0d: got %b expected %b", i, got, e); end
    end
    do_reset();
    @(negedge clk);
    n_checks++;
    if (fatal !== 1'b0) begin n_fail++; $display("FAIL fatal_clear: got %b expected 0", fatal); end
  endtask

  task automatic test_rst_resync();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      voter_state = (i < 2) ? 2'b10 : 2'b00;
      @(negedge clk);
    end
    n_checks++;
    if (core_rst_n !== 3'b101) begin n_fail++; $display("FAIL in_resync: got %b expected 101", core_rst_n); end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({core_rst_n, core_hold, mem_we_block, fault_cnt, core_disabled} !== {3'b111, 2'b00, 15'd0}) begin
      n_fail++;
      $display("FAIL async_rst: got %b %b %b %h %b expected 111 0 0 000 000",
               core_rst_n, core_hold, mem_we_block, fault_cnt, core_disabled);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_back_to_back();
    exp_t e, got;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      voter_state = 2'b01;
      exp_q.push_back(exp_fault(i, 3'b001, 3'b000, 0));
      @(negedge clk);
      got = got_vec(); e = exp_q.pop_front(); n_checks++;
      if (got !== e) begin n_fail++; $display("FAIL b2b_a cycle %0d: got %b expected %b", i, got, e); end
    end
    for (int i = 0; i < 13; i++) begin
      voter_state = (i == 0) ? 2'b01 : ((i < 3) ? 2'b10 : 2'b00);
      exp_q.push_back((i == 0) ? exp_fault(0, 3'b000, 3'b000, 3) : exp_fault(i - 1, 3'b010, 3'b000, 0));
      @(negedge clk);
      got = got_vec(); e = exp_q.pop_front(); n_checks++;
      if (got !== e) begin n_fail++; $display("FAIL b2b_relatch cycle %0d: got %b expected %b", i, got, e); end
    end
    for (int i = 0; i < 12; i++) begin
      voter_state = (i < 2) ? 2'b11 : 2'b00;
      exp_q.push_back(exp_fault(i, 3'b100, 3'b000, 0));
      @(negedge clk);
      got = got_vec(); e = exp_q.pop_front(); n_checks++;
      if (got !== e) begin n_fail++; $display("FAIL b2b_c cycle %0d: got %b expected %b", i, got, e); end
    end
  endtask

  initial begin
    test_reset();
    test_recovery_b();
    test_transient_a();
    test_retire();
    test_vote_fail();
    test_rst_resync();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
